// File: rtl/x3q16_pkg.sv
// rtl/x3q16_pkg.sv - shared width, mode encodings and FSM state type for x3q16_exec_unit
package x3q16_pkg;

    localparam int DATA_W = 16;

    localparam logic [2:0] MODE_ADD  = 3'b000;
    localparam logic [2:0] MODE_SUB  = 3'b001;
    localparam logic [2:0] MODE_MUL  = 3'b010;
    localparam logic [2:0] MODE_NAND = 3'b011;
    localparam logic [2:0] MODE_SHL  = 3'b100;
    localparam logic [2:0] MODE_SHR  = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/x3q16_mul_iter.sv
// rtl/x3q16_mul_iter.sv - shift-add multiplier, MUL_STEP bits per cycle, low 16 bits of a*b
module x3q16_mul_iter
    import x3q16_pkg::*;
#(
    parameter int MUL_STEP = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              done,
    output logic [DATA_W-1:0] product
);

    localparam int K = DATA_W / MUL_STEP;

    logic [DATA_W-1:0] acc_q;
    logic [DATA_W-1:0] mcand_q;
    logic [DATA_W-1:0] mplier_q;
    logic [DATA_W-1:0] partial;
    logic [3:0]        cnt_q;
    logic              run_q;

    always_comb begin
        partial = '0;
        for (int j = 0; j < MUL_STEP; j++) begin
            if (mplier_q[j]) begin
                partial = partial + (mcand_q << j);
            end
        end
    end

    // product already includes the current step so the final value is ready on the done edge
    assign product = acc_q + partial;
    assign done    = run_q && (cnt_q == 4'(K - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
        end else if (start) begin
            acc_q    <= '0;
            mcand_q  <= a;
            mplier_q <= b;
            cnt_q    <= '0;
            run_q    <= 1'b1;
        end else if (run_q) begin
            acc_q    <= product;
            mcand_q  <= mcand_q << MUL_STEP;
            mplier_q <= mplier_q >> MUL_STEP;
            cnt_q    <= done ? 4'd0 : cnt_q + 4'd1;
            run_q    <= !done;
        end
    end

endmodule

// File: rtl/x3q16_exec_unit.sv
// rtl/x3q16_exec_unit.sv - 16-bit request/response execution unit; X3Q16_FULL_MUL_EN selects the iterative full multiplier
module x3q16_exec_unit
    import x3q16_pkg::*;
#(
    parameter int MUL_STEP = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    input  logic [2:0]        req_mode,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_equal,
    output logic              rsp_greater,
    output logic              busy
);

    generate
        if (!(MUL_STEP == 1 || MUL_STEP == 2 || MUL_STEP == 4)) begin : g_bad_step
            $error("x3q16_exec_unit: MUL_STEP must be 1, 2 or 4");
        end
    endgenerate

    state_e            state_q;
    logic [DATA_W-1:0] result_q;
    logic              equal_q;
    logic              greater_q;
    logic [DATA_W-1:0] alu_result;
    logic              accept;

    assign req_ready   = (state_q == IDLE);
    assign rsp_valid   = (state_q == DONE);
    assign busy        = (state_q != IDLE);
    assign rsp_result  = result_q;
    assign rsp_equal   = equal_q;
    assign rsp_greater = greater_q;
    assign accept      = req_valid && req_ready;

    always_comb begin
        alu_result = '0;
        case (req_mode)
            MODE_ADD:  alu_result = req_a + req_b;
            MODE_SUB:  alu_result = req_a - req_b;
`ifdef X3Q16_FULL_MUL_EN
            MODE_MUL:  alu_result = '0;
`else
            MODE_MUL:  alu_result = 16'(req_a[7:0]) * 16'(req_b[7:0]);
`endif
            MODE_NAND: alu_result = ~(req_a & req_b);
            MODE_SHL:  alu_result = req_a << 1;
            MODE_SHR:  alu_result = req_a >> 1;
            default:   alu_result = '0;
        endcase
    end

`ifdef X3Q16_FULL_MUL_EN
    logic              mul_start;
    logic              mul_done;
    logic [DATA_W-1:0] mul_product;

    assign mul_start = accept && (req_mode == MODE_MUL);

    x3q16_mul_iter #(
        .MUL_STEP (MUL_STEP)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (req_a),
        .b       (req_b),
        .done    (mul_done),
        .product (mul_product)
    );
`endif

    // Operands are consumed on the accept edge, so flags are captured there and held until release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            result_q  <= '0;
            equal_q   <= 1'b0;
            greater_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        equal_q   <= (req_a == req_b);
                        greater_q <= ($signed(req_a) > $signed(req_b));
`ifdef X3Q16_FULL_MUL_EN
                        if (req_mode == MODE_MUL) begin
                            state_q <= MUL;
                        end else begin
                            result_q <= alu_result;
                            state_q  <= DONE;
                        end
`else
                        result_q <= alu_result;
                        state_q  <= DONE;
`endif
                    end
                end
`ifdef X3Q16_FULL_MUL_EN
                MUL: begin
                    if (mul_done) begin
                        result_q <= mul_product;
                        state_q  <= DONE;
                    end
                end
`endif
                DONE: begin
                    if (rsp_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_x3q16_exec_unit.sv
// tb/tb_x3q16_exec_unit.sv - directed vector bench for x3q16_exec_unit in either X3Q16_FULL_MUL_EN build
module tb_x3q16_exec_unit;

    localparam int MUL_STEP = 1;
`ifdef X3Q16_FULL_MUL_EN
    localparam int MUL_LAT = 16 / MUL_STEP + 1;
`else
    localparam int MUL_LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_a = '0;
    logic [15:0] req_b = '0;
    logic [2:0]  req_mode = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_result;
    logic        rsp_equal;
    logic        rsp_greater;
    logic        busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    x3q16_exec_unit #(.MUL_STEP(MUL_STEP)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_mode    (req_mode),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_equal   (rsp_equal),
        .rsp_greater (rsp_greater),
        .busy        (busy)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  mode;
        logic [15:0] res;
        logic        eq;
        logic        gt;
        int          lat;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Called #1 after a posedge with the unit idle; returns #1 after the edge where rsp_valid rose
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [2:0] m,
                          output int lat);
        req_a     = a;
        req_b     = b;
        req_mode  = m;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic release_rsp();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;

        vecs[0]  = '{16'h7FFF, 16'h0001, 3'd0, 16'h8000, 1'b0, 1'b1, 1};
        vecs[1]  = '{16'h0005, 16'h0005, 3'd1, 16'h0000, 1'b1, 1'b0, 1};
        vecs[2]  = '{16'hFFFF, 16'h0001, 3'd1, 16'hFFFE, 1'b0, 1'b0, 1};
        // 0x0123*0x0101 = 0x12423; low byte product 0x23*0x01 = 0x0023
`ifdef X3Q16_FULL_MUL_EN
        vecs[3]  = '{16'h0123, 16'h0101, 3'd2, 16'h2423, 1'b0, 1'b1, MUL_LAT};
        vecs[4]  = '{16'hFFFF, 16'hFFFF, 3'd2, 16'h0001, 1'b1, 1'b0, MUL_LAT};
`else
        vecs[3]  = '{16'h0123, 16'h0101, 3'd2, 16'h0023, 1'b0, 1'b1, MUL_LAT};
        vecs[4]  = '{16'hFFFF, 16'hFFFF, 3'd2, 16'hFE01, 1'b1, 1'b0, MUL_LAT};
`endif
        vecs[5]  = '{16'hF0F0, 16'hFF00, 3'd3, 16'h0FFF, 1'b0, 1'b0, 1};
        vecs[6]  = '{16'h8001, 16'h0000, 3'd4, 16'h0002, 1'b0, 1'b0, 1};
        vecs[7]  = '{16'h8001, 16'h8001, 3'd5, 16'h4000, 1'b1, 1'b0, 1};
        vecs[8]  = '{16'h1234, 16'h1234, 3'd7, 16'h0000, 1'b1, 1'b0, 1};
        vecs[9]  = '{16'h0002, 16'hFFFE, 3'd6, 16'h0000, 1'b0, 1'b1, 1};
        vecs[10] = '{16'hFFFF, 16'h0002, 3'd0, 16'h0001, 1'b0, 1'b0, 1};

        repeat (2) @(posedge clk);
        #1;
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_result", 32'(rsp_result), 32'h0);
        check("rst_equal", 32'(rsp_equal), 32'd0);
        check("rst_greater", 32'(rsp_greater), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_req_ready", 32'(req_ready), 32'd1);

        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].mode, lat);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("v%0d_result", i), 32'(rsp_result), 32'(vecs[i].res));
            check($sformatf("v%0d_equal", i), 32'(rsp_equal), 32'(vecs[i].eq));
            check($sformatf("v%0d_greater", i), 32'(rsp_greater), 32'(vecs[i].gt));
            release_rsp();
            check($sformatf("v%0d_idle_after", i), 32'(req_ready), 32'd1);
        end

        // Backpressure with a second request held the whole time
        run_op(16'h0003, 16'h0004, 3'd0, lat);
        req_a     = 16'h0010;
        req_b     = 16'h0020;
        req_mode  = 3'd0;
        req_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_req_ready", 32'(req_ready), 32'd0);
            check("bp_result", 32'(rsp_result), 32'h0007);
            check("bp_equal", 32'(rsp_equal), 32'd0);
            check("bp_greater", 32'(rsp_greater), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check("bp_release_idle", 32'(busy), 32'd0);
        check("bp_release_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("bp_second_valid", 32'(rsp_valid), 32'd1);
        check("bp_second_result", 32'(rsp_result), 32'h0030);
        release_rsp();

        // Reset mid-operation: five steps into the multiply, or with the response pending
        req_a     = 16'h0123;
        req_b     = 16'h0101;
        req_mode  = 3'd2;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
`ifdef X3Q16_FULL_MUL_EN
        repeat (5) @(posedge clk);
        #1;
        check("mid_busy_before", 32'(busy), 32'd1);
        check("mid_valid_before", 32'(rsp_valid), 32'd0);
`else
        check("mid_valid_before", 32'(rsp_valid), 32'd1);
`endif
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_result", 32'(rsp_result), 32'h0);
        check("mid_rst_equal", 32'(rsp_equal), 32'd0);
        check("mid_rst_greater", 32'(rsp_greater), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_req_ready", 32'(req_ready), 32'd1);
        check("mid_rst_no_rsp", 32'(rsp_valid), 32'd0);
        run_op(vecs[3].a, vecs[3].b, vecs[3].mode, lat);
        check("rerun_latency", 32'(lat), 32'(vecs[3].lat));
        check("rerun_result", 32'(rsp_result), 32'(vecs[3].res));
        check("rerun_greater", 32'(rsp_greater), 32'(vecs[3].gt));
        release_rsp();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
